// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES-128/192/256 encryptor, one round per clock over a single state register.
module aes_iter_cipher #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6,
  localparam int KS_W = 128 * (Nr + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    plaintext,
  input  logic [KS_W-1:0] key_sched,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    ciphertext,
  output logic            busy
);
  localparam int RW = $clog2(Nr + 1);
  localparam logic [RW-1:0] NR_R = RW'(Nr);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6) begin : g_bad_param
    $error("aes_iter_cipher: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t             state_q;
  logic [127:0]       st_q, st_d, ct_q;
  logic [RW-1:0]      rnd_q;
  logic [0:Nr][127:0] ks_q;
  logic               ov_q, accept, last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns; byte i sits at bits [127-8i -: 8], column-major.
  function automatic logic [127:0] round_f(input logic [127:0] s, input logic lst);
    logic [0:15][7:0] b;
    logic [0:3][7:0]  a;
    logic [127:0]     r;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = SBOX[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = b[4*((c+k)%4)+k];
      r[127-32*c -: 32] = lst ? a :
        {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
         a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
         a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
         xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
    end
    return r;
  endfunction

  assign in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept     = in_valid && in_ready;
  assign last       = rnd_q == NR_R;
  assign st_d       = round_f(st_q, last) ^ ks_q[rnd_q];
  assign busy       = state_q == ROUND;
  assign out_valid  = ov_q;
  assign ciphertext = ct_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      ks_q    <= '0;
      ov_q    <= 1'b0;
      ct_q    <= '0;
    end else if (accept) begin
      ks_q    <= key_sched;
      st_q    <= plaintext ^ key_sched[KS_W-1 -: 128];
      rnd_q   <= RW'(1);
      state_q <= ROUND;
      ov_q    <= 1'b0;
    end else if (state_q == ROUND) begin
      st_q    <= st_d;
      rnd_q   <= last ? rnd_q : rnd_q + 1'b1;
      state_q <= last ? DONE : ROUND;
      ov_q    <= last;
      ct_q    <= last ? st_d : ct_q;
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_iter_cipher.sv
// tb_aes_iter_cipher: FIPS-197 vectors, corner sequences and random streaming against a GF(2^8) AES model.
module tb_aes_iter_cipher;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] iv = '0, ordy = '1, ir, ov, bsy;
  logic [127:0] pt = '0;
  logic [1919:0] ks = '0;
  logic [2:0][127:0] ct;
  int checks = 0, errors = 0;
  logic [7:0] sbox_m [256];

  typedef struct {
    int           d;
    logic [127:0] p;
    logic [255:0] key;
    logic [127:0] e;
  } vec_t;
  vec_t tv [6];

  always #5 clk = ~clk;

  aes_iter_cipher #(.Nk(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .plaintext(pt), .key_sched(ks[1919 -: 1408]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .ciphertext(ct[0]), .busy(bsy[0]));
  aes_iter_cipher #(.Nk(6)) u6 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .plaintext(pt), .key_sched(ks[1919 -: 1664]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .ciphertext(ct[1]), .busy(bsy[1]));
  aes_iter_cipher #(.Nk(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .plaintext(pt), .key_sched(ks), .out_valid(ov[2]), .out_ready(ordy[2]),
    .ciphertext(ct[2]), .busy(bsy[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    logic [1919:0] r = '0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
      r[1919-32*i -: 32] = w[i];
    end
    return r;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [1919:0] k, input int nr);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = p[127-8*(4*c+r) -: 8] ^ k[1919-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox_m[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = (rd == nr) ? t[r][c] : gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] ^= k[1919-128*rd-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [127:0] p, input logic [1919:0] k);
    @(negedge clk);
    pt = p; ks = k; iv[d] = 1'b1;
    #1 chk("in_ready_at_accept", 128'(ir[d]), 128'd1);
    @(posedge clk);
    #1 iv[d] = 1'b0; pt = ~p; ks = ~k;
  endtask

  // Called just after the accept edge; counts cycles until out_valid and checks the result.
  task automatic wait_chk(input int d, input logic [127:0] e, input bit garble);
    int cyc = 1, bc = 0;
    while (cyc <= 60) begin
      @(negedge clk);
      if (ov[d]) break;
      bc += int'(bsy[d]);
      if (garble) begin
        iv[d] = (cyc >= 2 && cyc <= 8) ? cyc[0] : 1'b0;
        pt = rnd128(); ks = {15{rnd128()}};
      end
      @(posedge clk);
      cyc++;
    end
    chk("latency", 128'(cyc), 128'(11 + 2 * d));
    chk("busy_cycles", 128'(bc), 128'(10 + 2 * d));
    chk("ciphertext", ct[d], e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] p, e, c0, fips_pt;
    logic [255:0] key;
    logic [1919:0] k4;
    bit stable;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = '0, v;
      for (int y = 1; y < 256; y++) if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      v = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_m[x] = v;
    end
    fips_pt = 128'h00112233445566778899aabbccddeeff;
    k4 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    tv[0] = '{0, fips_pt, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tv[1] = '{1, fips_pt, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    tv[2] = '{2, fips_pt, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 128'h8ea2b7ca516745bfeafc49904b496089};
    for (int i = 3; i < 6; i++) begin
      tv[i].d = i - 3;
      tv[i].p = rnd128();
      tv[i].key = {rnd128(), rnd128()};
      tv[i].e = enc(tv[i].p, expand(tv[i].key, 4 + 2 * tv[i].d), 10 + 2 * tv[i].d);
    end
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 128'(ov), 128'd0);
    chk("reset_busy", 128'(bsy), 128'd0);
    chk("reset_ciphertext", ct[0] | ct[1] | ct[2], 128'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("idle_in_ready", 128'(ir), 128'd7);

    for (int i = 0; i < 6; i++) begin
      send(tv[i].d, tv[i].p, expand(tv[i].key, 4 + 2 * tv[i].d));
      wait_chk(tv[i].d, tv[i].e, 1'b0);
    end
    @(negedge clk);
    chk("drop_to_idle", 128'({ov[0], ir[0]}), 128'b01);
    chk("ct_holds_in_idle", ct[0], tv[3].e);

    // Backpressure, then accept on the same edge that releases the result.
    ordy[0] = 1'b0;
    p = rnd128(); key = {rnd128(), 128'h0};
    send(0, p, expand(key, 4));
    wait_chk(0, enc(p, expand(key, 4), 10), 1'b0);
    c0 = ct[0]; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ov[0] || ct[0] !== c0 || ir[0]) stable = 1'b0;
    end
    chk("backpressure_stable", 128'(stable), 128'd1);
    p = rnd128(); key = {rnd128(), 128'h0};
    @(negedge clk);
    ordy[0] = 1'b1; pt = p; ks = expand(key, 4); iv[0] = 1'b1;
    #1 chk("in_ready_done_and_out_ready", 128'(ir[0]), 128'd1);
    @(posedge clk);
    #1 iv[0] = 1'b0; pt = ~p; ks = ~ks;
    wait_chk(0, enc(p, expand(key, 4), 10), 1'b0);

    // Input noise while rounds execute must not disturb the block.
    send(0, fips_pt, k4);
    wait_chk(0, tv[0].e, 1'b1);
    @(negedge clk);
    chk("no_extra_accept", 128'({ov[0], bsy[0], ir[0]}), 128'b001);

    // Asynchronous reset in the middle of a block.
    send(0, fips_pt, k4);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_outputs", {ct[0][125:0], ov[0], bsy[0]}, 128'd0);
    chk("async_rst_in_ready", 128'(ir[0]), 128'd1);
    @(negedge clk) rst = 1'b0;
    send(0, fips_pt, k4);
    wait_chk(0, tv[0].e, 1'b0);

    // Back-to-back random blocks on the AES-192 instance.
    begin
      logic [127:0] exp_q [$];
      fork
        begin
          for (int i = 0; i < 8; i++) begin
            logic [127:0] sp;
            logic [1919:0] sk;
            int n = 0;
            @(negedge clk);
            sp = rnd128(); sk = expand({rnd128(), rnd128()}, 6);
            pt = sp; ks = sk; iv[1] = 1'b1;
            #1;
            while (!ir[1] && n < 100) begin
              @(negedge clk);
              #1 n++;
            end
            @(posedge clk);
            exp_q.push_back(enc(sp, sk, 12));
          end
          #1 iv[1] = 1'b0;
        end
        begin
          int got = 0, cyc = 0, lastc = 0;
          while (got < 8 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ov[1]) begin
              chk("stream_ciphertext", ct[1], exp_q.size() > 0 ? exp_q.pop_front() : ~ct[1]);
              if (got > 0) chk("stream_interval", 128'(cyc - lastc), 128'd13);
              lastc = cyc;
              got++;
            end
          end
          chk("stream_count", 128'(got), 128'd8);
        end
      join
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
